// File: rtl/sm83_bus_seq.sv
// sm83_bus_seq
// Bus-cycle sequencer sitting between the core microcode and the external
// memory bus. One memory request is accepted per M-cycle over a valid/ready
// handshake. The sequencer then drives address, write data and rd/wr strobes
// for TSTATES T-states, stretching the last T-state while ext_wait is high
// (bounded by MAX_WAIT), and returns read data with the IE register overlaid.
// It also holds the instruction register (IR) and the CB-prefix bank flag.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (accept when both high)
//   req_write, req_ir          request kind: write / opcode fetch
//   req_addr, req_wdata        request address and write data
//   rsp_valid, rsp_rdata       completion pulse and read data (held after)
//   rsp_tmo                    completion was forced by the wait timeout
//   ext_addr, ext_dout         bus address / write data
//   ext_din                    bus read data
//   ext_rd, ext_wr             bus strobes
//   ext_wait                   stretch request, looked at in last T-state only
//   ie_reg                     IE register, returned for reads of IE_ADDR
//   phase                      one-hot current T-state
//   ir                         instruction register (bypassed on load clock)
//   bank_cb, bank_we, bank_set CB-bank flag and its write port

module sm83_bus_seq #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int TSTATES  = 4,
    parameter int MAX_WAIT = 15,
    parameter int HI_CLR   = 8,
    parameter logic [ADDR_W-1:0] IE_ADDR = ADDR_W'('hFFFF)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_ir,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_tmo,
    output logic [ADDR_W-1:0]   ext_addr,
    output logic [DATA_W-1:0]   ext_dout,
    input  logic [DATA_W-1:0]   ext_din,
    output logic                ext_rd,
    output logic                ext_wr,
    input  logic                ext_wait,
    input  logic [DATA_W-1:0]   ie_reg,
    output logic [TSTATES-1:0]  phase,
    output logic [DATA_W-1:0]   ir,
    output logic                bank_cb,
    input  logic                bank_we,
    input  logic                bank_set
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(MAX_WAIT);
    localparam logic [TSTATES-1:0] PHASE_FIRST = TSTATES'(1);
    localparam logic [TSTATES-1:0] PHASE_LAST  = PHASE_FIRST << (TSTATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t                r_state;
    logic [TSTATES-1:0]    r_phase;
    logic [WCNT_W-1:0]     r_wait_cnt;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_dout;
    logic                  r_rd;
    logic                  r_wr;
    logic                  r_fetch;
    logic [DATA_W-1:0]     r_rdata;
    logic [DATA_W-1:0]     r_ir;
    logic                  r_bank_cb;

    logic                  w_last;
    logic                  w_busy;
    logic                  w_stall;
    logic                  w_complete;
    logic                  w_rd_done;
    logic                  w_ready;
    logic                  w_accept;
    logic [DATA_W-1:0]     w_rdata;
    logic [ADDR_W-1:0]     w_keep_mask;

    // Address bits that survive the end of a cycle; the top HI_CLR bits
    // are dropped so the bus shows only the low part between cycles.
    generate
        for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_keep
            assign w_keep_mask[gi] = (gi < ADDR_W - HI_CLR) ? 1'b1 : 1'b0;
        end
    endgenerate

    assign w_last     = r_phase[TSTATES-1];
    assign w_busy     = (r_state != S_IDLE);
    // Stretch the last T-state while the bus asks for it and budget remains.
    assign w_stall    = w_busy && w_last && ext_wait && (r_wait_cnt < WAIT_LIMIT);
    // Reset wins over a completion falling on the same clock: no response.
    assign w_complete = !reset && w_busy && w_last && !w_stall;
    assign w_rd_done  = w_complete && (r_state == S_RD);
    assign w_ready    = w_last && (!w_busy || w_complete);
    assign w_accept   = !reset && req_valid && w_ready;
    assign w_rdata    = (r_addr == IE_ADDR) ? ie_reg : ext_din;

    assign req_ready  = w_ready;
    assign rsp_valid  = w_complete;
    // ext_wait still high at completion means the budget ran out.
    assign rsp_tmo    = w_complete && ext_wait;
    assign rsp_rdata  = w_rd_done ? w_rdata : r_rdata;
    assign ir         = (w_rd_done && r_fetch) ? w_rdata : r_ir;
    assign ext_addr   = r_addr;
    assign ext_dout   = r_dout;
    assign ext_rd     = r_rd;
    assign ext_wr     = r_wr;
    assign phase      = r_phase;
    assign bank_cb    = r_bank_cb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_phase    <= PHASE_LAST;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_dout     <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_fetch    <= 1'b0;
            r_rdata    <= '0;
            r_ir       <= '0;
            r_bank_cb  <= 1'b0;
        end else begin
            if (bank_we) begin
                r_bank_cb <= bank_set;
            end

            if (w_accept) begin
                r_phase <= PHASE_FIRST;
            end else if (!w_stall) begin
                r_phase <= {r_phase[TSTATES-2:0], r_phase[TSTATES-1]};
            end

            if (w_stall) begin
                r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
            end else if (w_complete) begin
                r_wait_cnt <= '0;
            end

            if (w_rd_done) begin
                r_rdata <= w_rdata;
                if (r_fetch) begin
                    r_ir <= w_rdata;
                end
            end

            // A new accept overrides the end-of-cycle address clear so that
            // back-to-back cycles keep the full new address.
            if (w_accept) begin
                r_addr  <= req_addr;
                r_state <= req_write ? S_WR : S_RD;
                r_rd    <= !req_write;
                r_wr    <= req_write;
                r_fetch <= !req_write && req_ir;
                if (req_write) begin
                    r_dout <= req_wdata;
                end
            end else if (w_complete) begin
                r_addr  <= r_addr & w_keep_mask;
                r_state <= S_IDLE;
                r_rd    <= 1'b0;
                r_wr    <= 1'b0;
                r_fetch <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sm83_bus_seq.sv
// Directed testbench for sm83_bus_seq with default parameters
// (ADDR_W=16, DATA_W=8, TSTATES=4, MAX_WAIT=15, HI_CLR=8, IE_ADDR=FFFF).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.

module tb_sm83_bus_seq;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_ir;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_tmo;
    logic [15:0] ext_addr;
    logic [7:0]  ext_dout;
    logic [7:0]  ext_din;
    logic        ext_rd;
    logic        ext_wr;
    logic        ext_wait;
    logic [7:0]  ie_reg;
    logic [3:0]  phase;
    logic [7:0]  ir;
    logic        bank_cb;
    logic        bank_we;
    logic        bank_set;

    int n_tests;
    int n_fail;

    sm83_bus_seq dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_ir    (req_ir),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_tmo   (rsp_tmo),
        .ext_addr  (ext_addr),
        .ext_dout  (ext_dout),
        .ext_din   (ext_din),
        .ext_rd    (ext_rd),
        .ext_wr    (ext_wr),
        .ext_wait  (ext_wait),
        .ie_reg    (ie_reg),
        .phase     (phase),
        .ir        (ir),
        .bank_cb   (bank_cb),
        .bank_we   (bank_we),
        .bank_set  (bank_set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Step falling edges until the last T-state, bounded.
    task automatic to_last();
        for (int i = 0; i < 8; i++) begin
            if (phase[3] === 1'b1) break;
            @(negedge clk);
            #1;
        end
        chk("reach_last", 32'(phase[3]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_ir    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        ext_din   = '0;
        ext_wait  = 1'b0;
        ie_reg    = '0;
        bank_we   = 1'b0;
        bank_set  = 1'b0;
        repeat (2) @(posedge clk);

        // ---- reset state
        @(negedge clk); reset = 1'b0; #1;
        chk("rst_phase",  32'(phase),     32'h8);
        chk("rst_ready",  32'(req_ready), 32'h1);
        chk("rst_rd",     32'(ext_rd),    32'h0);
        chk("rst_wr",     32'(ext_wr),    32'h0);
        chk("rst_addr",   32'(ext_addr),  32'h0);
        chk("rst_dout",   32'(ext_dout),  32'h0);
        chk("rst_valid",  32'(rsp_valid), 32'h0);
        chk("rst_tmo",    32'(rsp_tmo),   32'h0);
        chk("rst_rdata",  32'(rsp_rdata), 32'h0);
        chk("rst_ir",     32'(ir),        32'h0);
        chk("rst_bank",   32'(bank_cb),   32'h0);
        $display("[TB] reset state checked");

        // ---- T1: read 0x1234, ext_din=0x5A in phase 3
        req_valid = 1'b1; req_write = 1'b0; req_ir = 1'b0; req_addr = 16'h1234; #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        @(negedge clk); req_valid = 1'b0; req_addr = 16'hFFFF; #1;
        chk("t1_ph0",    32'(phase),     32'h1);
        chk("t1_rd0",    32'(ext_rd),    32'h1);
        chk("t1_addr",   32'(ext_addr),  32'h1234);
        chk("t1_nordy",  32'(req_ready), 32'h0);
        @(negedge clk); #1;
        chk("t1_ph1",    32'(phase),     32'h2);
        chk("t1_rd1",    32'(ext_rd),    32'h1);
        @(negedge clk); #1;
        chk("t1_ph2",    32'(phase),     32'h4);
        chk("t1_novld",  32'(rsp_valid), 32'h0);
        @(negedge clk); ext_din = 8'h5A; #1;
        chk("t1_ph3",    32'(phase),     32'h8);
        chk("t1_rd3",    32'(ext_rd),    32'h1);
        chk("t1_vld",    32'(rsp_valid), 32'h1);
        chk("t1_rdata",  32'(rsp_rdata), 32'h5A);
        chk("t1_tmo",    32'(rsp_tmo),   32'h0);
        @(negedge clk); ext_din = 8'h00; #1;
        chk("t1_hiclr",  32'(ext_addr),  32'h0034);
        chk("t1_rdoff",  32'(ext_rd),    32'h0);
        chk("t1_pulse",  32'(rsp_valid), 32'h0);
        chk("t1_hold",   32'(rsp_rdata), 32'h5A);
        chk("t1_ir",     32'(ir),        32'h0);
        $display("[TB] T1 read 0x1234 -> rdata %0h", rsp_rdata);

        // ---- T2: write C000/77 then back-to-back read C000
        to_last();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'hC000; req_wdata = 8'h77; #1;
        chk("t2_ready", 32'(req_ready), 32'h1);
        @(negedge clk); req_wdata = 8'h00; req_write = 1'b0; #1;
        chk("t2_ph0",   32'(phase),     32'h1);
        chk("t2_wr",    32'(ext_wr),    32'h1);
        chk("t2_nord",  32'(ext_rd),    32'h0);
        chk("t2_dout",  32'(ext_dout),  32'h77);
        chk("t2_nordy", 32'(req_ready), 32'h0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); ext_din = 8'h99; #1;
        chk("t2_wph3",  32'(phase),     32'h8);
        chk("t2_wvld",  32'(rsp_valid), 32'h1);
        chk("t2_b2b",   32'(req_ready), 32'h1);
        chk("t2_wrdat", 32'(rsp_rdata), 32'h5A);
        chk("t2_wr3",   32'(ext_wr),    32'h1);
        @(negedge clk); req_valid = 1'b0; #1;
        chk("t2_rph0",  32'(phase),     32'h1);
        chk("t2_rd",    32'(ext_rd),    32'h1);
        chk("t2_wroff", 32'(ext_wr),    32'h0);
        chk("t2_raddr", 32'(ext_addr),  32'hC000);
        chk("t2_dhold", 32'(ext_dout),  32'h77);
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("t2_rvld",  32'(rsp_valid), 32'h1);
        chk("t2_rdata", 32'(rsp_rdata), 32'h99);
        chk("t2_dout2", 32'(ext_dout),  32'h77);
        @(negedge clk); #1;
        chk("t2_hiclr", 32'(ext_addr),  32'h0000);
        chk("t2_rdoff", 32'(ext_rd),    32'h0);
        chk("t2_dout3", 32'(ext_dout),  32'h77);
        $display("[TB] T2 write/read C000 -> rdata %0h dout %0h", rsp_rdata, ext_dout);

        // ---- T3: wait high 3 clocks in phase 3
        to_last();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0100; #1;
        @(negedge clk); req_valid = 1'b0; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); ext_wait = 1'b1; #1;
        chk("t3_st1ph", 32'(phase),     32'h8);
        chk("t3_st1",   32'(rsp_valid), 32'h0);
        @(negedge clk); #1;
        chk("t3_st2ph", 32'(phase),     32'h8);
        chk("t3_st2",   32'(rsp_valid), 32'h0);
        @(negedge clk); #1;
        chk("t3_st3ph", 32'(phase),     32'h8);
        chk("t3_st3",   32'(rsp_valid), 32'h0);
        @(negedge clk); ext_wait = 1'b0; ext_din = 8'h3C; #1;
        chk("t3_ph",    32'(phase),     32'h8);
        chk("t3_vld",   32'(rsp_valid), 32'h1);
        chk("t3_tmo",   32'(rsp_tmo),   32'h0);
        chk("t3_rdata", 32'(rsp_rdata), 32'h3C);
        @(negedge clk); #1;
        chk("t3_adv",   32'(phase),     32'h1);
        $display("[TB] T3 3-clock wait -> rdata %0h", rsp_rdata);

        // ---- T4: wait stuck high, timeout after 15 stall clocks
        to_last();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h2000; #1;
        @(negedge clk); req_valid = 1'b0; ext_wait = 1'b1; ext_din = 8'h11; #1;
        to_last();
        chk("t4_st0", 32'(rsp_valid), 32'h0);
        for (int i = 1; i < 15; i++) begin
            @(negedge clk); #1;
            chk("t4_stall",   32'(rsp_valid), 32'h0);
            chk("t4_stallph", 32'(phase),     32'h8);
        end
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h3000; req_wdata = 8'h42; #1;
        chk("t4_vld",   32'(rsp_valid), 32'h1);
        chk("t4_tmo",   32'(rsp_tmo),   32'h1);
        chk("t4_rdata", 32'(rsp_rdata), 32'h11);
        chk("t4_ready", 32'(req_ready), 32'h1);
        @(negedge clk); req_valid = 1'b0; ext_wait = 1'b0; #1;
        chk("t4_wr",    32'(ext_wr),    32'h1);
        chk("t4_addr",  32'(ext_addr),  32'h3000);
        chk("t4_ph0",   32'(phase),     32'h1);
        to_last();
        chk("t4_wvld",  32'(rsp_valid), 32'h1);
        chk("t4_wtmo",  32'(rsp_tmo),   32'h0);
        chk("t4_dout",  32'(ext_dout),  32'h42);
        $display("[TB] T4 timeout read then write 3000/%0h", ext_dout);

        // ---- T5: opcode fetch from IE_ADDR, bank flag write
        req_valid = 1'b1; req_write = 1'b0; req_ir = 1'b1; req_addr = 16'hFFFF;
        ie_reg = 8'h1F; ext_din = 8'hEE; bank_we = 1'b1; bank_set = 1'b1; #1;
        chk("t5_ready", 32'(req_ready), 32'h1);
        @(negedge clk); req_valid = 1'b0; req_ir = 1'b0; bank_we = 1'b0; bank_set = 1'b0; #1;
        chk("t5_bank",  32'(bank_cb),   32'h1);
        chk("t5_ph0",   32'(phase),     32'h1);
        chk("t5_addr",  32'(ext_addr),  32'hFFFF);
        chk("t5_ir0",   32'(ir),        32'h0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("t5_vld",   32'(rsp_valid), 32'h1);
        chk("t5_irbyp", 32'(ir),        32'h1F);
        chk("t5_rdata", 32'(rsp_rdata), 32'h1F);
        @(negedge clk); ie_reg = 8'h00; #1;
        chk("t5_irreg", 32'(ir),        32'h1F);
        chk("t5_hiclr", 32'(ext_addr),  32'h00FF);
        chk("t5_bank2", 32'(bank_cb),   32'h1);
        $display("[TB] T5 fetch IE -> ir %0h bank_cb %0d", ir, bank_cb);

        // ---- T6: reset in phase 2 of a write
        to_last();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h5555; req_wdata = 8'hAB; #1;
        @(negedge clk); req_valid = 1'b0; #1;
        @(negedge clk); #1;
        @(negedge clk); reset = 1'b1; #1;
        chk("t6_ph2",   32'(phase),     32'h4);
        chk("t6_novld", 32'(rsp_valid), 32'h0);
        @(negedge clk); #1;
        chk("t6_wr",    32'(ext_wr),    32'h0);
        chk("t6_phase", 32'(phase),     32'h8);
        chk("t6_ir",    32'(ir),        32'h0);
        chk("t6_bank",  32'(bank_cb),   32'h0);
        chk("t6_vld",   32'(rsp_valid), 32'h0);
        chk("t6_dout",  32'(ext_dout),  32'h0);
        chk("t6_addr",  32'(ext_addr),  32'h0);
        reset = 1'b0;
        $display("[TB] T6 reset mid-write -> ext_wr %0d phase %0h", ext_wr, phase);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
